call_stack: RTL and testbench

- Hardware LIFO on the downstream side of the pipelined-multiplier instruction decoder.
- Consumes the decoder's push/pop strobes (issued in phase e1 of a stk instruction).
- Supplies top-of-stack data to the register-file write mux (mux1 select 3) and the PC load mux (pcmux select 2).
- Returns the full/empty status that the decoder uses to gate pops and PC loads.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/call_stack.sv | 94 +++++++++
 tb/tb_call_stack.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and mux select encodings.
// The decoder and the call stack both import these so they agree on widths and select codes.
package cpu_pkg;

    localparam int DATA_W      = 16;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        MUX1_ALU   = 2'b00,
        MUX1_MEM   = 2'b01,
        MUX1_IMM   = 2'b10,
        MUX1_STACK = 2'b11
    } mux1_sel_e;

    typedef enum logic [1:0] {
        PCMUX_INC    = 2'b00,
        PCMUX_BRANCH = 2'b01,
        PCMUX_STACK  = 2'b10,
        PCMUX_HOLD   = 2'b11
    } pcmux_sel_e;

endpackage

// File: rtl/call_stack.sv
// Hardware LIFO for the decoder's stk instructions.
// It provides a zero-latency top-of-stack output and sticky overflow/underflow flags.
module call_stack #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::STACK_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clr_err,
    output logic [DATA_W-1:0] pop_data,
    output logic              stack_full,
    output logic              stack_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int SP_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   top_idx;
    logic              wr_en;
    logic [SP_W-1:0]   wr_idx;
    logic              do_push;
    logic              do_pop;

    // sp is count modulo DEPTH, so when full, sp-1 wraps onto the last entry
    assign top_idx     = sp - SP_W'(1);
    assign stack_full  = (count == CNT_W'(DEPTH));
    assign stack_empty = (count == '0);
    assign pop_data    = stack_empty ? '0 : mem[top_idx];

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = sp;
        if (push_en && pop_en) begin
            wr_en = 1'b1;
            if (stack_empty) begin
                do_push = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (push_en) begin
            do_push = !stack_full;
            wr_en   = !stack_full;
        end else if (pop_en) begin
            do_pop = !stack_empty;
        end
    end

    // Storage is not reset, but writes are still suppressed while reset is high
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                sp    <= sp + SP_W'(1);
                count <= count + CNT_W'(1);
            end else if (do_pop) begin
                sp    <= top_idx;
                count <= count - CNT_W'(1);
            end

            if (push_en && !pop_en && stack_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (pop_en && stack_empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack.
// Directed scenarios plus random traffic, all checked against a queue-based LIFO model.
module tb_call_stack;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push_en = 1'b0;
    logic          pop_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] pop_data;
    logic          stack_full;
    logic          stack_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    call_stack #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_en    (push_en),
        .pop_en     (pop_en),
        .push_data  (push_data),
        .clr_err    (clr_err),
        .pop_data   (pop_data),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: a queue whose back is the top of stack
    int unsigned m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input bit p, input bit q, input bit c, input int unsigned d);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (p && q) begin
            if (m_q.size() == 0) begin
                m_q.push_back(d);
                m_unf = 1'b1;
            end else begin
                m_q[m_q.size()-1] = d;
            end
        end else if (p) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (q) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = m_q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(stack_full), 32'(n == DEPTH));
        chk({tag, ".pop_data"}, 32'(pop_data), (n == 0) ? 32'd0 : 32'(m_q[n-1]));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input bit p, input bit q, input bit c, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        push_en   = p;
        pop_en    = q;
        clr_err   = c;
        push_data = d;
        @(posedge clk);
        model_apply(p, q, c, 32'(d));
        #1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        bit p, q, c;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.pop_data_zero", 32'(pop_data), 32'h0000);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, "idle");

        step(1, 0, 0, 16'h1111, "push1");
        step(1, 0, 0, 16'h2222, "push2");
        step(1, 0, 0, 16'h3333, "push3");
        chk("lifo.top3", 32'(pop_data), 32'h3333);
        step(0, 1, 0, '0, "pop1");
        chk("lifo.top2", 32'(pop_data), 32'h2222);
        step(0, 1, 0, '0, "pop2");
        chk("lifo.top1", 32'(pop_data), 32'h1111);
        step(0, 1, 0, '0, "pop3");
        chk("lifo.empty_data", 32'(pop_data), 32'h0000);

        for (int i = 0; i < 16; i++) step(1, 0, 0, DW'(16'h0100 + i), "fill");
        chk("fill.full", 32'(stack_full), 32'd1);
        step(1, 0, 0, 16'hDEAD, "overpush");
        chk("overpush.ovf", 32'(overflow), 32'd1);
        chk("overpush.top", 32'(pop_data), 32'h010F);
        step(1, 1, 0, 16'hBEEF, "replace_full");
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0, "drain");
        step(0, 0, 1, '0, "clr_ovf");

        step(0, 1, 0, '0, "underpop");
        chk("underpop.unf", 32'(underflow), 32'd1);
        step(0, 0, 1, '0, "clr_unf");
        chk("clr_unf.unf", 32'(underflow), 32'd0);

        step(1, 0, 0, 16'hAAAA, "push_a");
        step(1, 1, 0, 16'hBBBB, "replace");
        chk("replace.top", 32'(pop_data), 32'hBBBB);
        step(0, 1, 0, '0, "pop_b");
        step(1, 1, 0, 16'hCCCC, "pushpop_empty");
        chk("pushpop_empty.top", 32'(pop_data), 32'hCCCC);
        chk("pushpop_empty.unf", 32'(underflow), 32'd1);
        step(0, 1, 1, '0, "clr_and_pop");
        step(0, 1, 1, '0, "clr_vs_set");

        for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(16'h5000 + i), "pre_rst");
        @(negedge clk);
        #2;
        push_en   = 1'b1;
        push_data = 16'h9999;
        reset     = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset   = 1'b0;
        push_en = 1'b0;
        step(1, 0, 0, 16'h7777, "post_rst");
        chk("post_rst.top", 32'(pop_data), 32'h7777);

        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 8);
            d = DW'($urandom);
            step(p, q, c, d, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
